element_delay_accumulator: RTL and testbench

ELEMENT_DELAY_ACCUMULATOR -- requirements
Module: element_delay_accumulator

---
 rtl/beamform_pkg.sv | 28 ++
 rtl/delay_side_stepper.sv | 59 +++++
 rtl/element_delay_accumulator.sv | 143 ++++++++++++++
 tb/tb_element_delay_accumulator.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beamform_pkg.sv
// Shared types and width helpers for the beamforming delay path.
package beamform_pkg;

    localparam int unsigned DW_INTEGER_DEF  = 18;
    localparam int unsigned DW_FRACTION_DEF = 6;
    localparam int unsigned DW_DELAY_DEF    = 12;
    localparam int unsigned MAX_STEPS_DEF   = 8;

    // Signed K_n term width and error accumulator width (one guard bit).
    localparam int unsigned TERM_W_DEF = DW_INTEGER_DEF + DW_FRACTION_DEF + 1;
    localparam int unsigned ACC_W_DEF  = TERM_W_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TERM,
        ST_ADJUST,
        ST_OUTPUT
    } state_t;

    function automatic int unsigned term_width(input int unsigned di, input int unsigned df);
        return di + df + 1;
    endfunction

    function automatic int unsigned acc_width(input int unsigned di, input int unsigned df);
        return term_width(di, df) + 1;
    endfunction

endpackage

// File: rtl/delay_side_stepper.sv
// One-side delay/error adjust step. DELAY_SATURATE_EN selects hold-at-max
// instead of wrap on increment overflow.
module delay_side_stepper
    import beamform_pkg::*;
#(
    parameter int unsigned DW_FRACTION = DW_FRACTION_DEF,
    parameter int unsigned DW_DELAY    = DW_DELAY_DEF,
    parameter int unsigned ACC_W       = ACC_W_DEF
) (
    input  logic        [DW_DELAY-1:0] d,
    input  logic signed [ACC_W-1:0]    e,
    output logic        [DW_DELAY-1:0] d_next,
    output logic signed [ACC_W-1:0]    e_next,
    output logic                       changed,
    output logic                       ovf
);

    // Wide enough that (2d+1)<<DW_FRACTION and e never overflow the compare.
    localparam int unsigned CW = ACC_W + DW_DELAY + DW_FRACTION + 2;

    logic signed [CW-1:0] e_w;
    logic signed [CW-1:0] d_w;
    logic signed [CW-1:0] d_sh;
    logic signed [CW-1:0] inc_step;
    logic signed [CW-1:0] dec_step;

    always_comb begin
        e_w      = {{(CW-ACC_W){e[ACC_W-1]}}, e};
        d_w      = {{(CW-DW_DELAY){1'b0}}, d};
        d_sh     = d_w <<< DW_FRACTION;
        inc_step = (d_w + d_w + CW'(1)) <<< DW_FRACTION;
        dec_step = (d_w + d_w - CW'(1)) <<< DW_FRACTION;

        d_next  = d;
        e_next  = e;
        changed = 1'b0;
        ovf     = 1'b0;

        if (e_w >= d_sh) begin
            ovf = (d == '1);
`ifdef DELAY_SATURATE_EN
            if (d != '1) begin
                d_next  = d + 1'b1;
                e_next  = ACC_W'(e_w - inc_step);
                changed = 1'b1;
            end
`else
            d_next  = d + 1'b1;
            e_next  = ACC_W'(e_w - inc_step);
            changed = 1'b1;
`endif
        end else if ((e_w < -d_sh) && (d != '0)) begin
            d_next  = d - 1'b1;
            e_next  = ACC_W'(e_w + dec_step);
            changed = 1'b1;
        end
    end

endmodule

// File: rtl/element_delay_accumulator.sv
// Per-element integer delay tracker driven by K_n error terms.
// Optional DELAY_SATURATE_EN: hold delays at max instead of wrapping.
module element_delay_accumulator
    import beamform_pkg::*;
#(
    parameter int unsigned DW_INTEGER  = DW_INTEGER_DEF,
    parameter int unsigned DW_FRACTION = DW_FRACTION_DEF,
    parameter int unsigned DW_DELAY    = DW_DELAY_DEF,
    parameter int unsigned MAX_STEPS   = MAX_STEPS_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic        [DW_DELAY-1:0]            r0_delay,
    input  logic signed [DW_INTEGER+DW_FRACTION:0] term_pos,
    input  logic signed [DW_INTEGER+DW_FRACTION:0] term_neg,
    input  logic                                  term_ready,
    input  logic                                  last_element,
    output logic                                  term_ack,
    output logic        [DW_DELAY-1:0]            delay_pos,
    output logic        [DW_DELAY-1:0]            delay_neg,
    output logic        [5:0]                     element_idx,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  done,
    output logic                                  overflow
);

    localparam int unsigned ACC_W = acc_width(DW_INTEGER, DW_FRACTION);
    localparam int unsigned SCW   = $clog2(MAX_STEPS + 1);

    state_t                    state;
    logic signed [ACC_W-1:0]   e_pos;
    logic signed [ACC_W-1:0]   e_neg;
    logic                      last_q;
    logic        [SCW-1:0]     step_cnt;

    logic        [DW_DELAY-1:0] d_pos_nx;
    logic        [DW_DELAY-1:0] d_neg_nx;
    logic signed [ACC_W-1:0]    e_pos_nx;
    logic signed [ACC_W-1:0]    e_neg_nx;
    logic                       chg_pos;
    logic                       chg_neg;
    logic                       ovf_pos;
    logic                       ovf_neg;

    delay_side_stepper #(
        .DW_FRACTION (DW_FRACTION),
        .DW_DELAY    (DW_DELAY),
        .ACC_W       (ACC_W)
    ) u_step_pos (
        .d       (delay_pos),
        .e       (e_pos),
        .d_next  (d_pos_nx),
        .e_next  (e_pos_nx),
        .changed (chg_pos),
        .ovf     (ovf_pos)
    );

    delay_side_stepper #(
        .DW_FRACTION (DW_FRACTION),
        .DW_DELAY    (DW_DELAY),
        .ACC_W       (ACC_W)
    ) u_step_neg (
        .d       (delay_neg),
        .e       (e_neg),
        .d_next  (d_neg_nx),
        .e_next  (e_neg_nx),
        .changed (chg_neg),
        .ovf     (ovf_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            e_pos       <= '0;
            e_neg       <= '0;
            last_q      <= 1'b0;
            step_cnt    <= '0;
            term_ack    <= 1'b0;
            delay_pos   <= '0;
            delay_neg   <= '0;
            element_idx <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            term_ack <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        delay_pos   <= r0_delay;
                        delay_neg   <= r0_delay;
                        e_pos       <= '0;
                        e_neg       <= '0;
                        element_idx <= 6'd1;
                        overflow    <= 1'b0;
                        state       <= ST_WAIT_TERM;
                    end
                end
                ST_WAIT_TERM: begin
                    if (term_ready) begin
                        e_pos    <= e_pos + ACC_W'(term_pos);
                        e_neg    <= e_neg + ACC_W'(term_neg);
                        last_q   <= last_element;
                        step_cnt <= '0;
                        term_ack <= 1'b1;
                        state    <= ST_ADJUST;
                    end
                end
                ST_ADJUST: begin
                    delay_pos <= d_pos_nx;
                    delay_neg <= d_neg_nx;
                    e_pos     <= e_pos_nx;
                    e_neg     <= e_neg_nx;
                    overflow  <= overflow | ovf_pos | ovf_neg;
                    // Exit on a quiet cycle or once the step budget is spent.
                    if (!(chg_pos || chg_neg) || (step_cnt == SCW'(MAX_STEPS - 1))) begin
                        out_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            element_idx <= element_idx + 1'b1;
                            state       <= ST_WAIT_TERM;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_element_delay_accumulator.sv
// Self-checking bench: directed table, hand-written corner sequences and
// randomized sweeps against an integer-arithmetic reference model.
module tb_element_delay_accumulator;

    localparam int DI    = 18;
    localparam int DF    = 6;
    localparam int DD    = 12;
    localparam int MS    = 8;
    localparam int TW    = DI + DF + 1;
    localparam longint SCALE = 64;
    localparam longint DMAX  = 4095;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [DD-1:0]        r0_delay = '0;
    logic signed [TW-1:0] term_pos = '0;
    logic signed [TW-1:0] term_neg = '0;
    logic                 term_ready = 1'b0;
    logic                 last_element = 1'b0;
    logic                 term_ack;
    logic [DD-1:0]        delay_pos;
    logic [DD-1:0]        delay_neg;
    logic [5:0]           element_idx;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 done;
    logic                 overflow;

    always #5 clk = ~clk;

    element_delay_accumulator #(
        .DW_INTEGER  (DI),
        .DW_FRACTION (DF),
        .DW_DELAY    (DD),
        .MAX_STEPS   (MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .r0_delay     (r0_delay),
        .term_pos     (term_pos),
        .term_neg     (term_neg),
        .term_ready   (term_ready),
        .last_element (last_element),
        .term_ack     (term_ack),
        .delay_pos    (delay_pos),
        .delay_neg    (delay_neg),
        .element_idx  (element_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .done         (done),
        .overflow     (overflow)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: delays/errors as plain integers, error in 1/SCALE units.
    longint md_p, md_n, me_p, me_n;
    bit     movf;

    task automatic model_side(inout longint d, inout longint e, output bit ch);
        ch = 1'b0;
        if (e >= d * SCALE) begin
            if (d == DMAX) begin
                movf = 1'b1;
`ifndef DELAY_SATURATE_EN
                e  = e - (2 * d + 1) * SCALE;
                d  = 0;
                ch = 1'b1;
`endif
            end else begin
                e  = e - (2 * d + 1) * SCALE;
                d  = d + 1;
                ch = 1'b1;
            end
        end else if (e < -(d * SCALE) && d > 0) begin
            e  = e + (2 * d - 1) * SCALE;
            d  = d - 1;
            ch = 1'b1;
        end
    endtask

    task automatic model_start(input longint r0);
        md_p = r0; md_n = r0; me_p = 0; me_n = 0; movf = 1'b0;
    endtask

    task automatic model_element(input longint tp, input longint tn, output int cycles);
        bit cp, cn;
        int steps;
        me_p += tp;
        me_n += tn;
        cycles = 0;
        steps  = 0;
        for (int k = 0; k < MS + 1; k++) begin
            cycles++;
            model_side(md_p, me_p, cp);
            model_side(md_n, me_n, cn);
            if (!(cp || cn)) break;
            steps++;
            if (steps == MS) break;
        end
    endtask

    task automatic do_start(input int r0);
        r0_delay = DD'(r0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_element(input string tag, input longint tp, input longint tn, input bit last,
                               input longint exp_dp, input longint exp_dn, input bit exp_ovf,
                               input int exp_idx, input int exp_cyc, input int stall);
        int  n;
        int  viol;
        bit  ack_again;
        term_pos     = TW'(tp);
        term_neg     = TW'(tn);
        last_element = last;
        term_ready   = 1'b1;
        tick();
        term_ready = 1'b0;
        check({tag, "/ack"}, longint'(term_ack), 1);
        n = 0;
        ack_again = 1'b0;
        while (!out_valid && n < 64) begin
            tick();
            n++;
            if (term_ack) ack_again = 1'b1;
        end
        check({tag, "/ack_once"}, longint'(ack_again), 0);
        check({tag, "/adj_cycles"}, n, exp_cyc);
        check({tag, "/delay_pos"}, longint'(delay_pos), exp_dp);
        check({tag, "/delay_neg"}, longint'(delay_neg), exp_dn);
        check({tag, "/idx"}, longint'(element_idx), exp_idx);
        check({tag, "/overflow"}, longint'(overflow), exp_ovf);
        if (stall > 0) begin
            viol = 0;
            for (int i = 0; i < stall; i++) begin
                tick();
                if (!out_valid || term_ack || longint'(delay_pos) != exp_dp ||
                    longint'(delay_neg) != exp_dn || int'(element_idx) != exp_idx) viol++;
            end
            check({tag, "/stall_stable"}, viol, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/valid_drop"}, longint'(out_valid), 0);
        check({tag, "/done"}, longint'(done), longint'(last));
        if (last) begin
            tick();
            check({tag, "/done_pulse"}, longint'(done), 0);
        end
    endtask

    typedef struct {
        int     r0;
        longint tp;
        longint tn;
        longint dp;
        longint dn;
        bit     ovf;
        int     cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int viol;
        int nel;
        int r0;
        int dc0;
        longint tp, tn;

        vecs[0] = '{100, 0, 0, 100, 100, 1'b0, 1};
        vecs[1] = '{100, 12864, -12736, 101, 99, 1'b0, 2};
        vecs[2] = '{10, 64000, 0, 18, 10, 1'b0, 8};
`ifdef DELAY_SATURATE_EN
        vecs[3] = '{4095, 262080, 0, 4095, 4095, 1'b1, 1};
`else
        vecs[3] = '{4095, 262080, 0, 0, 4095, 1'b1, 2};
`endif
        vecs[4] = '{0, 0, -640, 1, 0, 1'b0, 2};
        vecs[5] = '{5, 320, 0, 6, 5, 1'b0, 2};

        repeat (2) @(posedge clk);
        #1;
        check("rst/delay_pos", longint'(delay_pos), 0);
        check("rst/delay_neg", longint'(delay_neg), 0);
        check("rst/idx", longint'(element_idx), 0);
        check("rst/valid", longint'(out_valid), 0);
        check("rst/ack", longint'(term_ack), 0);
        check("rst/ovf", longint'(overflow), 0);
        rst_n = 1'b1;
        term_ready = 1'b1;
        repeat (3) tick();
        term_ready = 1'b0;
        check("idle_no_action", longint'(term_ack) + longint'(out_valid) + longint'(delay_pos), 0);

        foreach (vecs[i]) begin
            do_start(vecs[i].r0);
            run_element($sformatf("vec%0d", i), vecs[i].tp, vecs[i].tn, 1'b1,
                        vecs[i].dp, vecs[i].dn, vecs[i].ovf, 1, vecs[i].cyc, 0);
        end

        // Three-element sweep with a 20-cycle stall on element 2.
        dc0 = done_cnt;
        do_start(100);
        model_start(100);
        for (int el = 0; el < 3; el++) begin
            tp = (el == 1) ? 12864 : 3000;
            tn = -2000;
            model_element(tp, tn, cyc);
            run_element($sformatf("sweep_e%0d", el + 1), tp, tn, el == 2,
                        md_p, md_n, movf, el + 1, cyc, (el == 1) ? 20 : 0);
        end
        check("sweep/done_count", done_cnt - dc0, 1);

        // start while waiting for terms is ignored.
        do_start(100);
        run_element("ign_e1", 0, 0, 1'b0, 100, 100, 1'b0, 1, 1, 0);
        r0_delay = DD'(50);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_element("ign_e2", 0, 0, 1'b1, 100, 100, 1'b0, 2, 1, 0);

        // Reset in the middle of ADJUST.
        do_start(10);
        term_pos = TW'(64000);
        term_neg = '0;
        last_element = 1'b1;
        term_ready = 1'b1;
        tick();
        term_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst/delay_pos", longint'(delay_pos), 0);
        check("midrst/delay_neg", longint'(delay_neg), 0);
        check("midrst/idx", longint'(element_idx), 0);
        check("midrst/valid_ack_done_ovf",
              longint'({out_valid, term_ack, done, overflow}), 0);
        tick();
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid || term_ack || done || delay_pos != '0) viol++;
        end
        check("midrst/quiet", viol, 0);
        do_start(100);
        run_element("post_rst", 0, 0, 1'b1, 100, 100, 1'b0, 1, 1, 0);

        // Randomized sweeps against the model.
        for (int s = 0; s < 12; s++) begin
            nel = int'($urandom_range(1, 4));
            r0  = (s % 4 == 3) ? int'($urandom_range(4085, 4095)) : int'($urandom_range(0, 4095));
            do_start(r0);
            model_start(r0);
            for (int el = 0; el < nel; el++) begin
                tp = longint'($urandom_range(0, 2 ** 21)) - 2 ** 20;
                tn = longint'($urandom_range(0, 2 ** 21)) - 2 ** 20;
                model_element(tp, tn, cyc);
                run_element($sformatf("rnd%0d_e%0d", s, el + 1), tp, tn, el == nel - 1,
                            md_p, md_n, movf, el + 1, cyc, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
